// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback
// for add, sub, and, or, slt, lw, sw, beq with a memory-ack timeout.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   instr, zero         IR contents, ALU zero flag
//   mem_ack             memory handshake (only meaningful while mem_req=1)
//   mem_req, mem_we     memory request and write qualifier
//   iord                memory address select (0 PC, 1 ALUOut)
//   ir_write, pc_write  IR and PC load strobes
//   pc_src              PC source (00 ALU, 01 ALUOut)
//   alu_src_a/b, alu_op ALU operand selects and operation
//   reg_write, reg_dst  register file write enable and destination select
//   mem_to_reg          writeback source (0 ALUOut, 1 MDR)
//   state, illegal      debug state and error flag
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [3:0]  state,
    output logic        illegal
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_LW_WB     = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_ERROR     = 4'd15
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    logic [5:0] op;
    logic [5:0] funct;
    logic       r_legal;
    logic       waiting;
    logic       timeout;
    logic       unused_bits;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign unused_bits = ^instr[25:6];

    assign r_legal = (op == OP_R) &&
                     (funct == 6'b100000 || funct == 6'b100010 ||
                      funct == 6'b100100 || funct == 6'b100101 ||
                      funct == 6'b101010);

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_WRITE);
    // ack wins over timeout when both land in the same cycle
    assign timeout = waiting && !mem_ack && (wait_cnt_q == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ack)      state_d = S_DECODE;
                else if (timeout) state_d = S_ERROR;
            end
            S_DECODE: begin
                if (r_legal)                         state_d = S_R_EXEC;
                else if (op == OP_LW || op == OP_SW) state_d = S_MEM_ADDR;
                else if (op == OP_BEQ)               state_d = S_BRANCH;
                else                                 state_d = S_ERROR;
            end
            S_MEM_ADDR:  state_d = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (mem_ack)      state_d = S_LW_WB;
                else if (timeout) state_d = S_ERROR;
            end
            S_LW_WB:     state_d = S_FETCH;
            S_MEM_WRITE: begin
                if (mem_ack)      state_d = S_FETCH;
                else if (timeout) state_d = S_ERROR;
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_ERROR:     state_d = S_ERROR;
            default:     state_d = S_ERROR;
        endcase
    end

    // Any state change clears the counter, covering entry to each wait state
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q)
            wait_cnt_d = '0;
        else if (waiting && !mem_ack)
            wait_cnt_d = wait_cnt_q + CW'(1);
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        state      = 4'd0;
        illegal    = 1'b0;
        if (rst_n) begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ack;
                    pc_write  = mem_ack;
                end
                S_DECODE:   alu_src_b = 2'b11;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_READ: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_LW_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    case (funct)
                        6'b100010: alu_op = 3'b001;
                        6'b100100: alu_op = 3'b010;
                        6'b100101: alu_op = 3'b011;
                        6'b101010: alu_op = 3'b100;
                        default:   alu_op = 3'b000;
                    endcase
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 3'b001;
                    pc_src    = 2'b01;
                    pc_write  = zero;
                end
                S_ERROR:  illegal = 1'b1;
                default:  illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed cycle table plus randomized
// instruction/handshake stimulus checked against a step-list reference model.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    localparam logic [31:0] ADD  = 32'h00221820;
    localparam logic [31:0] SUB  = 32'h00221822;
    localparam logic [31:0] LW   = 32'h8C220004;
    localparam logic [31:0] SW   = 32'hAC220004;
    localparam logic [31:0] BEQ  = 32'h10220003;
    localparam logic [31:0] BAD0 = 32'h00000000;
    localparam logic [31:0] BAD1 = 32'h20220004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0]  pc_src, alu_src_b;
    logic        alu_src_a;
    logic [2:0]  alu_op;
    logic        reg_write, reg_dst, mem_to_reg;
    logic [3:0]  state;
    logic        illegal;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .state(state), .illegal(illegal)
    );

    int nvec = 0;
    int nbad = 0;
    int cyc  = 0;

    typedef struct {
        logic        r;
        logic [31:0] in;
        logic        a;
        logic        z;
        logic [3:0]  st;
        logic        req;
        logic        irw;
        logic        pcw;
        logic        rw;
        logic [2:0]  aop;
        logic        ill;
        bit          chk;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [31:0] in, logic a, logic z,
                                logic [3:0] st, logic req, logic irw,
                                logic pcw, logic rw, logic [2:0] aop,
                                logic ill);
        vec_t v;
        v.r = r; v.in = in; v.a = a; v.z = z; v.st = st; v.req = req;
        v.irw = irw; v.pcw = pcw; v.rw = rw; v.aop = aop; v.ill = ill;
        v.chk = 1'b1;
        return v;
    endfunction

    // Reference model: the current step plus the list of steps left in
    // the instruction; memory steps count waited cycles.
    int m_code = 0;
    int m_path[$];
    int m_waits = 0;

    function automatic logic [20:0] model_out(int code, logic r, logic a,
                                              logic z, logic [5:0] fn);
        logic       req, we, io, irw, pcw, sa, rw, rd, m2r, ill;
        logic [1:0] ps, sb;
        logic [2:0] aop;
        logic [3:0] st;
        {req, we, io, irw, pcw, sa, rw, rd, m2r, ill} = '0;
        ps = 2'b00; sb = 2'b00; aop = 3'b000; st = 4'd0;
        if (r) begin
            st = 4'(code);
            case (code)
                0: begin req = 1; sb = 2'b01; irw = a; pcw = a; end
                1: sb = 2'b11;
                2: begin sa = 1; sb = 2'b10; end
                3: begin req = 1; io = 1; end
                4: begin rw = 1; m2r = 1; end
                5: begin req = 1; we = 1; io = 1; end
                6: begin
                    sa = 1;
                    case (fn)
                        6'h22:   aop = 3'd1;
                        6'h24:   aop = 3'd2;
                        6'h25:   aop = 3'd3;
                        6'h2a:   aop = 3'd4;
                        default: aop = 3'd0;
                    endcase
                end
                7: begin rw = 1; rd = 1; end
                8: begin sa = 1; aop = 3'd1; ps = 2'b01; pcw = z; end
                default: ill = 1;
            endcase
        end
        return {req, we, io, irw, pcw, ps, sa, sb, aop, rw, rd, m2r, st, ill};
    endfunction

    task automatic model_advance();
        logic [5:0] op, fn;
        m_waits = 0;
        if (m_code == 1) begin
            op = instr[31:26];
            fn = instr[5:0];
            m_path.delete();
            if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                                fn == 6'h25 || fn == 6'h2a))
                m_path = '{6, 7};
            else if (op == 6'h23) m_path = '{2, 3, 4};
            else if (op == 6'h2b) m_path = '{2, 5};
            else if (op == 6'h04) m_path = '{8};
            else                  m_path = '{15};
        end
        if (m_code == 0)             m_code = 1;
        else if (m_path.size() == 0) m_code = 0;
        else                         m_code = m_path.pop_front();
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_code = 0;
            m_waits = 0;
            m_path.delete();
        end else if (m_code == 15) begin
            m_code = 15;
        end else if (m_code == 0 || m_code == 3 || m_code == 5) begin
            if (mem_ack)               model_advance();
            else if (m_waits == TO - 1) m_code = 15;
            else                       m_waits++;
        end else begin
            model_advance();
        end
    endtask

    task automatic apply(input vec_t v);
        logic [20:0] act, exp;
        logic [11:0] tact, texp;
        rst_n = v.r; instr = v.in; mem_ack = v.a; zero = v.z;
        #1;
        act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
               alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, state,
               illegal};
        exp = model_out(m_code, v.r, v.a, v.z, v.in[5:0]);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL model cyc=%0d got=%h want=%h", cyc, act, exp);
        end
        if (v.chk) begin
            tact = {state, mem_req, ir_write, pc_write, reg_write, alu_op,
                    illegal};
            texp = {v.st, v.req, v.irw, v.pcw, v.rw, v.aop, v.ill};
            nvec++;
            if (tact !== texp) begin
                nbad++;
                $display("FAIL table cyc=%0d got=%h want=%h", cyc, tact, texp);
            end
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] b;
        b = $urandom;
        case ($urandom_range(0, 10))
            0: return {6'h00, b[25:6], 6'h20};
            1: return {6'h00, b[25:6], 6'h22};
            2: return {6'h00, b[25:6], 6'h24};
            3: return {6'h00, b[25:6], 6'h25};
            4: return {6'h00, b[25:6], 6'h2a};
            5: return {6'h23, b[25:0]};
            6: return {6'h2b, b[25:0]};
            7: return {6'h04, b[25:0]};
            8: return {6'h00, b[25:6], 6'h00};
            9: return {6'h08, b[25:0]};
            default: return b;
        endcase
    endfunction

    initial begin
        vec_t v;
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, ADD, 1, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, ADD, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, ADD, 1, 0, 6, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, ADD, 1, 0, 7, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, SUB, 1, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, SUB, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, SUB, 1, 0, 6, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, SUB, 1, 0, 7, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, LW, 1, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, LW, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, LW, 1, 0, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, LW, 0, 0, 3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, LW, 0, 0, 3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, LW, 1, 0, 3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, LW, 1, 0, 4, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, BEQ, 1, 1, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, BEQ, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, BEQ, 1, 1, 8, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, BEQ, 1, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, BEQ, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, BEQ, 1, 0, 8, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, BAD0, 1, 1, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, BAD0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 20; i++) tbl.push_back(mk(1, BAD0, 1, 1, 15, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, BAD1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, BAD1, 1, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, BAD1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, BAD1, 1, 0, 15, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, SW, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, SW, 1, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, SW, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, SW, 1, 0, 2, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, SW, 0, 0, 5, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, SW, 0, 0, 15, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, SW, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, SW, 1, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, SW, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, SW, 1, 0, 2, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, SW, 0, 0, 5, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, SW, 1, 0, 5, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, ADD, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, ADD, 1, 0, 0, 1, 1, 1, 0, 0, 0));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        v = mk(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.chk = 1'b0;
        v.in = instr;
        for (int i = 0; i < 4000; i++) begin
            if (m_code == 15) v.r = ($urandom_range(0, 3) != 0);
            else              v.r = ($urandom_range(0, 199) != 0);
            if (m_code == 0) v.in = rand_instr();
            v.a = ($urandom_range(0, 3) != 0);
            v.z = 1'($urandom_range(0, 1));
            apply(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
